// File: rtl/vx_fpu_packet_split.sv
// rtl/vx_fpu_packet_split.sv - splits a warp-wide FPU request into lane-sized packets
module vx_fpu_packet_split #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int LANE_W      = 96,
  parameter int META_W      = 64,
  localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int PID_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_THREADS-1:0]        in_tmask,
  input  logic [NUM_THREADS*LANE_W-1:0] in_data,
  input  logic [META_W-1:0]             in_meta,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES-1:0]          out_tmask,
  output logic [NUM_LANES*LANE_W-1:0]   out_data,
  output logic [META_W-1:0]             out_meta,
  output logic [PID_W-1:0]              out_pid,
  output logic                          out_sop,
  output logic                          out_eop
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                        state;
  logic                          valid_q;
  logic [NUM_THREADS-1:0]        tmask_q;
  logic [NUM_THREADS*LANE_W-1:0] data_q;
  logic [NUM_PKTS-1:0]           rem_q;

  logic                          in_fire;
  logic                          out_fire;
  logic [NUM_THREADS-1:0]        src_mask;
  logic [NUM_THREADS*LANE_W-1:0] src_data;
  logic [NUM_PKTS-1:0]           src_act;
  logic [NUM_PKTS-1:0]           nxt_rem;
  logic [PID_W-1:0]              nxt_pid;
  logic [NUM_LANES-1:0]          nxt_tmask;
  logic [NUM_LANES*LANE_W-1:0]   nxt_data;
  logic                          nxt_eop;

  // out_valid is masked while reset is held so a pending packet vanishes immediately
  assign out_valid = valid_q && !reset;
  assign in_ready  = !reset && ((state == IDLE) || (out_valid && out_ready && out_eop));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // One scanner serves both the first packet of a new request and each advance;
  // rem_q holds the active packets not yet emitted, excluding the current one.
  always_comb begin
    src_mask  = in_fire ? in_tmask : tmask_q;
    src_data  = in_fire ? in_data : data_q;
    nxt_pid   = '0;
    nxt_tmask = '0;
    nxt_data  = '0;
    nxt_rem   = '0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      src_act[p] = in_fire ? (|in_tmask[p*NUM_LANES +: NUM_LANES]) : rem_q[p];
    end
    for (int p = NUM_PKTS - 1; p >= 0; p--) begin
      if (src_act[p]) nxt_pid = PID_W'(p);
    end
    for (int p = 0; p < NUM_PKTS; p++) begin
      if (PID_W'(p) == nxt_pid) begin
        nxt_tmask = src_mask[p*NUM_LANES +: NUM_LANES];
        nxt_data  = src_data[p*NUM_LANES*LANE_W +: NUM_LANES*LANE_W];
      end
      nxt_rem[p] = src_act[p] && (PID_W'(p) != nxt_pid);
    end
    nxt_eop = ~|nxt_rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      out_tmask <= '0;
      out_pid   <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      rem_q     <= '0;
    end else if (in_fire) begin
      state     <= BUSY;
      valid_q   <= 1'b1;
      tmask_q   <= in_tmask;
      data_q    <= in_data;
      out_meta  <= in_meta;
      out_tmask <= nxt_tmask;
      out_data  <= nxt_data;
      out_pid   <= nxt_pid;
      out_sop   <= 1'b1;
      out_eop   <= nxt_eop;
      rem_q     <= nxt_rem;
    end else if (out_fire) begin
      if (out_eop) begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end else begin
        out_tmask <= nxt_tmask;
        out_data  <= nxt_data;
        out_pid   <= nxt_pid;
        out_sop   <= 1'b0;
        out_eop   <= nxt_eop;
        rem_q     <= nxt_rem;
      end
    end
  end

endmodule

// File: tb/tb_vx_fpu_packet_split.sv
// tb/tb_vx_fpu_packet_split.sv - directed self-checking bench for vx_fpu_packet_split
module tb_vx_fpu_packet_split;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_tmask = '0;
  logic [63:0] in_data = '0;
  logic [15:0] in_meta = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_tmask;
  logic [15:0] out_data;
  logic [15:0] out_meta;
  logic [1:0]  out_pid;
  logic        out_sop;
  logic        out_eop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_fpu_packet_split #(
    .NUM_THREADS(8), .NUM_LANES(2), .LANE_W(8), .META_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
    .in_data(in_data), .in_meta(in_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_tmask(out_tmask),
    .out_data(out_data), .out_meta(out_meta), .out_pid(out_pid),
    .out_sop(out_sop), .out_eop(out_eop)
  );

  // thread i carries byte seed+i
  function automatic logic [63:0] mk_data(input logic [7:0] seed);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = seed + 8'(i);
    return d;
  endfunction

  function automatic logic [15:0] pkt_data(input logic [7:0] seed, input int p);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = seed + 8'(2 * p);
    hi = seed + 8'(2 * p + 1);
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0h exp 0", in_ready); end
    checks++; if (out_tmask !== 2'b00) begin errors++; $display("FAIL rst_tmask got %0h exp 0", out_tmask); end
    checks++; if (out_pid !== 2'd0) begin errors++; $display("FAIL rst_pid got %0h exp 0", out_pid); end
    checks++; if (out_sop !== 1'b0) begin errors++; $display("FAIL rst_sop got %0h exp 0", out_sop); end
    checks++; if (out_eop !== 1'b0) begin errors++; $display("FAIL rst_eop got %0h exp 0", out_eop); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0h exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %0h exp 0", out_valid); end
  endtask

  task automatic test_full_mask();
    tick();
    in_valid = 1'b1; in_tmask = 8'hFF; in_data = mk_data(8'h10); in_meta = 16'hA5A5; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_accept got %0h exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid p%0d got %0h exp 1", p, out_valid); end
      checks++; if (out_pid !== 2'(p)) begin errors++; $display("FAIL full_pid got %0h exp %0h", out_pid, p); end
      checks++; if (out_tmask !== 2'b11) begin errors++; $display("FAIL full_tmask p%0d got %0h exp 3", p, out_tmask); end
      checks++; if (out_sop !== (p == 0)) begin errors++; $display("FAIL full_sop p%0d got %0h exp %0h", p, out_sop, p == 0); end
      checks++; if (out_eop !== (p == 3)) begin errors++; $display("FAIL full_eop p%0d got %0h exp %0h", p, out_eop, p == 3); end
      checks++; if (out_data !== pkt_data(8'h10, p)) begin errors++; $display("FAIL full_data p%0d got %0h exp %0h", p, out_data, pkt_data(8'h10, p)); end
      checks++; if (out_meta !== 16'hA5A5) begin errors++; $display("FAIL full_meta p%0d got %0h exp a5a5", p, out_meta); end
      checks++; if (in_ready !== (p == 3)) begin errors++; $display("FAIL full_in_ready p%0d got %0h exp %0h", p, in_ready, p == 3); end
      tick(); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_idle got %0h exp 0", out_valid); end
  endtask

  task automatic test_sparse_mask();
    logic [1:0] exp_pid [2];
    logic [1:0] exp_tm [2];
    exp_pid[0] = 2'd0; exp_tm[0] = 2'b01;
    exp_pid[1] = 2'd2; exp_tm[1] = 2'b11;
    tick();
    in_valid = 1'b1; in_tmask = 8'b0011_0001; in_data = mk_data(8'h30); in_meta = 16'h1234;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sparse_accept got %0h exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid k%0d got %0h exp 1", k, out_valid); end
      checks++; if (out_pid !== exp_pid[k]) begin errors++; $display("FAIL sparse_pid k%0d got %0h exp %0h", k, out_pid, exp_pid[k]); end
      checks++; if (out_tmask !== exp_tm[k]) begin errors++; $display("FAIL sparse_tmask k%0d got %0h exp %0h", k, out_tmask, exp_tm[k]); end
      checks++; if (out_sop !== (k == 0)) begin errors++; $display("FAIL sparse_sop k%0d got %0h exp %0h", k, out_sop, k == 0); end
      checks++; if (out_eop !== (k == 1)) begin errors++; $display("FAIL sparse_eop k%0d got %0h exp %0h", k, out_eop, k == 1); end
      checks++; if (out_data !== pkt_data(8'h30, int'(exp_pid[k]))) begin errors++; $display("FAIL sparse_data k%0d got %0h exp %0h", k, out_data, pkt_data(8'h30, int'(exp_pid[k]))); end
      checks++; if (out_meta !== 16'h1234) begin errors++; $display("FAIL sparse_meta k%0d got %0h exp 1234", k, out_meta); end
      tick(); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_idle got %0h exp 0", out_valid); end
  endtask

  task automatic test_zero_mask();
    tick();
    in_valid = 1'b1; in_tmask = 8'h00; in_data = mk_data(8'h50); in_meta = 16'h0F0F;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0h exp 1", out_valid); end
    checks++; if (out_pid !== 2'd0) begin errors++; $display("FAIL zero_pid got %0h exp 0", out_pid); end
    checks++; if (out_tmask !== 2'b00) begin errors++; $display("FAIL zero_tmask got %0h exp 0", out_tmask); end
    checks++; if (out_sop !== 1'b1) begin errors++; $display("FAIL zero_sop got %0h exp 1", out_sop); end
    checks++; if (out_eop !== 1'b1) begin errors++; $display("FAIL zero_eop got %0h exp 1", out_eop); end
    checks++; if (out_meta !== 16'h0F0F) begin errors++; $display("FAIL zero_meta got %0h exp f0f", out_meta); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_idle got %0h exp 0", out_valid); end
  endtask

  task automatic test_stall();
    tick();
    in_valid = 1'b1; in_tmask = 8'hFF; in_data = mk_data(8'h70); in_meta = 16'h5555; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_pid !== 2'd0) begin errors++; $display("FAIL stall_pid0 got %0h exp 0", out_pid); end
    for (int c = 0; c < 5; c++) begin
      tick();
      out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %0h exp 1", c, out_valid); end
      checks++; if (out_pid !== 2'd1) begin errors++; $display("FAIL stall_pid c%0d got %0h exp 1", c, out_pid); end
      checks++; if (out_data !== pkt_data(8'h70, 1)) begin errors++; $display("FAIL stall_data c%0d got %0h exp %0h", c, out_data, pkt_data(8'h70, 1)); end
      checks++; if ({out_tmask, out_sop, out_eop} !== 4'b1100) begin errors++; $display("FAIL stall_flags c%0d got %0h exp c", c, {out_tmask, out_sop, out_eop}); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got %0h exp 0", c, in_ready); end
    end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (out_pid !== 2'd1) begin errors++; $display("FAIL stall_release_pid got %0h exp 1", out_pid); end
    tick(); #1;
    checks++; if (out_pid !== 2'd2) begin errors++; $display("FAIL stall_next_pid got %0h exp 2", out_pid); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid got %0h exp 1", out_valid); end
    tick(); #1;
    checks++; if (out_pid !== 2'd3 || out_eop !== 1'b1) begin errors++; $display("FAIL stall_last got pid %0h eop %0h exp pid 3 eop 1", out_pid, out_eop); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %0h exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    tick();
    in_valid = 1'b1; in_tmask = 8'hC0; in_data = mk_data(8'h40); in_meta = 16'hC0C0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept1 got %0h exp 1", in_ready); end
    tick();
    in_tmask = 8'h03; in_data = mk_data(8'h80); in_meta = 16'h0303;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd3) begin errors++; $display("FAIL b2b_pkt1 got valid %0h pid %0h exp valid 1 pid 3", out_valid, out_pid); end
    checks++; if ({out_sop, out_eop} !== 2'b11) begin errors++; $display("FAIL b2b_pkt1_flags got %0h exp 3", {out_sop, out_eop}); end
    checks++; if (out_data !== pkt_data(8'h40, 3)) begin errors++; $display("FAIL b2b_pkt1_data got %0h exp %0h", out_data, pkt_data(8'h40, 3)); end
    checks++; if (out_meta !== 16'hC0C0) begin errors++; $display("FAIL b2b_pkt1_meta got %0h exp c0c0", out_meta); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0h exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd0) begin errors++; $display("FAIL b2b_pkt2 got valid %0h pid %0h exp valid 1 pid 0", out_valid, out_pid); end
    checks++; if ({out_tmask, out_sop, out_eop} !== 4'b1111) begin errors++; $display("FAIL b2b_pkt2_flags got %0h exp f", {out_tmask, out_sop, out_eop}); end
    checks++; if (out_data !== pkt_data(8'h80, 0)) begin errors++; $display("FAIL b2b_pkt2_data got %0h exp %0h", out_data, pkt_data(8'h80, 0)); end
    checks++; if (out_meta !== 16'h0303) begin errors++; $display("FAIL b2b_pkt2_meta got %0h exp 303", out_meta); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0h exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    tick();
    in_valid = 1'b1; in_tmask = 8'hFF; in_data = mk_data(8'h20); in_meta = 16'h7777; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_pid !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pid0 got valid %0h pid %0h exp valid 1 pid 0", out_valid, out_pid); end
    tick();
    out_ready = 1'b0; reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_during_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_during_in_ready got %0h exp 0", in_ready); end
    tick();
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_tmask = 8'h0C; in_data = mk_data(8'h60); in_meta = 16'h6060;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_after_in_ready got %0h exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd1) begin errors++; $display("FAIL rmid_new_pkt got valid %0h pid %0h exp valid 1 pid 1", out_valid, out_pid); end
    checks++; if ({out_tmask, out_sop, out_eop} !== 4'b1111) begin errors++; $display("FAIL rmid_new_flags got %0h exp f", {out_tmask, out_sop, out_eop}); end
    checks++; if (out_data !== pkt_data(8'h60, 1)) begin errors++; $display("FAIL rmid_new_data got %0h exp %0h", out_data, pkt_data(8'h60, 1)); end
    checks++; if (out_meta !== 16'h6060) begin errors++; $display("FAIL rmid_new_meta got %0h exp 6060", out_meta); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle got %0h exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
